telem_frame_bank: RTL
=====================

# telem_frame_bank

Parametrised telemetry register bank with frame capture and streaming output. Holds CHANNELS independently addressable WIDTH-bit coordinate/time registers. On a commit pulse it copies all channels atomically into a shadow frame. It then streams that frame one channel per beat over a valid/ready interface to the downlink formatter.

## Interface
Parameters:
- WIDTH, 8, bits per channel register
- CHANNELS, 4, number of channel registers (default order: X, Y, Z, time); legal range 2..256
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= CHANNELS

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  reset, synchronous and active-high
- wr_en  input  1  write strobe for holding registers
- wr_addr  input  ADDR_W  target channel for write
- wr_data  input  WIDTH  write data
- rd_addr  input  ADDR_W  readback channel select
- rd_data  output  WIDTH  combinational readback of holding register rd_addr; 0 if out of range
- commit  input  1  capture all holding registers into the shadow frame and start streaming
- out_data  output  WIDTH  current beat
- out_valid  output  1  beat valid
- out_ready  input  1  sink accepts beat
- out_last  output  1  final beat of frame, qualified by out_valid
- busy  output  1  high while state is SEND
- overrun  output  1  one-cycle pulse when a commit is rejected

## Operation
- Holding registers: on wr_en, hold[wr_addr] <= wr_data. Channels not addressed keep their value (load/hold per register). A wr_addr >= CHANNELS is ignored with no side effect.
- FSM states: IDLE, SEND.
- IDLE, commit=1:
  - shadow[i] <= hold[i] for all i, using pre-edge values. A write in the same cycle lands in hold, not in shadow.
  - beat index <= 0.
  - next state SEND.
- SEND:
  - out_valid=1 and out_data=beat[idx].
  - A transfer occurs when out_valid && out_ready. On transfer, idx increments.
  - On transfer of the final beat (out_last=1), next state is IDLE.
- Commit while in SEND is rejected, including in the cycle the final beat transfers:
  - the shadow is unchanged;
  - overrun pulses high on the next cycle;
  - the holding registers are unaffected.
- out_data and out_last are stable while out_valid=1 and out_ready=0.
- Beat sequence without TELEM_SEQ_EN: shadow[0] .. shadow[CHANNELS-1]; out_last on shadow[CHANNELS-1].
- rst: all holding and shadow registers cleared to 0. FSM goes to IDLE and idx to 0. out_valid=0, out_last=0, busy=0, overrun=0, sequence counter=0. Reset mid-frame aborts the frame; there is no partial-frame completion after reset.

## Timing
- Write latency: 1 cycle. rd_data reflects a write in the cycle after wr_en.
- Commit latency: commit sampled at edge n → out_valid=1, busy=1 in cycle n+1 with the first beat.
- Throughput: with out_ready held high, one beat per cycle and no bubbles. A frame occupies exactly B cycles (B = beats per frame).
- After the final-beat transfer at edge m, busy=0 and out_valid=0 in cycle m+1. The earliest accepted commit is sampled at edge m+1.
- overrun is registered: it is high in the cycle after the rejected commit, for one cycle only.

## Configuration
- TELEM_SEQ_EN defined:
  - Each frame is prefixed by a sequence beat carrying an 8-bit frame counter, zero-extended or truncated to WIDTH.
  - B = CHANNELS+1.
  - The counter captures its value at commit and increments once per accepted commit, wrapping 255→0.
  - Rejected commits do not increment it.
- TELEM_SEQ_EN undefined: no sequence beat, B = CHANNELS, and no counter logic.

## Test plan
- Reset then readback: rst=1 for 2 cycles, then sweep rd_addr 0..3 → rd_data=0, out_valid=0, busy=0, overrun=0.
- Write/commit/stream, no SEQ, defaults: write X=0x11, Y=0x22, Z=0x33, T=0x44; commit with out_ready=1 → beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_last on 0x44, busy low next cycle.
- Backpressure and atomicity: after commit, hold out_ready=0 for 5 cycles while writing X=0xAA → out_data stays 0x11, stable. Release → frame still 0x11, 0x22, 0x33, 0x44; rd_data(0)=0xAA.
- Overrun: commit at cycle 1 of SEND and again on the final-beat cycle → two overrun pulses, shadow unchanged, no second frame. A commit one cycle later is accepted.
- Same-cycle write+commit, plus an out-of-range write to wr_addr=7 → frame carries old X; hold X updated; channel registers unchanged by the address-7 write.
- With TELEM_SEQ_EN: three accepted commits → leading beats 0x00, 0x01, 0x02, B=5, out_last on the time beat. Reset mid-frame → out_valid=0 next cycle; the next frame's sequence beat is 0x00.

Source files
------------

// File: rtl/telem_frame_bank_if.sv
// Bus bundle for telem_frame_bank: holding-register write/readback port,
// commit strobe, and the valid/ready beat stream toward the downlink formatter.
interface telem_frame_bank_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              commit;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overrun;

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, commit, out_ready,
        output rd_data, out_data, out_valid, out_last, busy, overrun
    );

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, commit, out_ready,
        input  rd_data, out_data, out_valid, out_last, busy, overrun
    );
endinterface

// File: rtl/telem_frame_bank.sv
// Telemetry register bank: CHANNELS holding registers, atomic commit into a shadow
// frame, then one beat per channel over valid/ready. Define TELEM_SEQ_EN to prefix frames with a sequence beat.
module telem_frame_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 8
) (
    input logic               clk,
    input logic               rst,
    telem_frame_bank_if.slave bus
);

`ifdef TELEM_SEQ_EN
    localparam int BEATS = CHANNELS + 1;
`else
    localparam int BEATS = CHANNELS;
`endif
    localparam int             IDX_W    = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_d;
    logic             start;
    logic             reject;
    logic             valid;
    logic             last;
    logic             overrun_q;
    logic [WIDTH-1:0] beat;
    logic [WIDTH-1:0] rd_mux;

    logic [WIDTH-1:0] hold   [CHANNELS];
    logic [WIDTH-1:0] shadow [CHANNELS];

`ifdef TELEM_SEQ_EN
    logic [7:0] seq_cnt;
    logic [7:0] seq_frame;

    // Zero-extend or truncate the 8-bit frame counter onto the beat width.
    function automatic logic [WIDTH-1:0] fit_seq(input logic [7:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH && i < 8; i++) begin
            r[i] = v[i];
        end
        return r;
    endfunction
`endif

    // Holding registers; out-of-range addresses match no channel and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                hold[i] <= '0;
            end
        end else if (bus.wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.wr_addr == ADDR_W'(i)) begin
                    hold[i] <= bus.wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.rd_addr == ADDR_W'(i)) begin
                rd_mux = hold[i];
            end
        end
    end

    // Shadow captures pre-edge hold contents, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= hold[i];
            end
        end
    end

`ifdef TELEM_SEQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt   <= '0;
            seq_frame <= '0;
        end else if (start) begin
            seq_frame <= seq_cnt;
            seq_cnt   <= seq_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            overrun_q <= reject;
        end
    end

    // Commits are rejected for the whole of SEND, including the final-beat cycle.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        start   = 1'b0;
        reject  = 1'b0;
        valid   = 1'b0;
        last    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.commit) begin
                    start   = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                valid  = 1'b1;
                last   = (idx == LAST_IDX);
                reject = bus.commit;
                if (bus.out_ready) begin
                    if (last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        beat = '0;
`ifdef TELEM_SEQ_EN
        if (idx == '0) begin
            beat = fit_seq(seq_frame);
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_W'(i + 1)) begin
                beat = shadow[i];
            end
        end
`else
        for (int i = 0; i < CHANNELS; i++) begin
            if (idx == IDX_W'(i)) begin
                beat = shadow[i];
            end
        end
`endif
    end

    assign bus.rd_data   = rd_mux;
    assign bus.out_data  = beat;
    assign bus.out_valid = valid;
    assign bus.out_last  = last;
    assign bus.busy      = valid;
    assign bus.overrun   = overrun_q;

endmodule
